// File: rtl/termgrid_pkg.sv
// termgrid shared types: FSM states, control/character constants and helpers.
package termgrid_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_UPDATE,
    S_CLEAR,
    S_HDR,
    S_ROW,
    S_CR,
    S_LF
  } state_t;

  localparam logic [7:0] CH_ESC    = 8'h1B;
  localparam logic [7:0] CH_LBRACK = 8'h5B;
  localparam logic [7:0] CH_H      = 8'h48;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_BS     = 8'h08;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  // Grid RAM address width for a rows x cols screen.
  function automatic int unsigned addr_width(input int unsigned rows, input int unsigned cols);
    return $clog2(rows * cols);
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/termgrid_ram.sv
// termgrid character store: single port, synchronous write, registered read.
module termgrid_ram
  import termgrid_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write on we; the addressed cell is always read into rdata one cycle later.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/termgrid.sv
// termgrid: COLS x ROWS terminal screen buffer with full-screen redraw output.
// Optional feature macro: TERMGRID_SCROLL_EN (scroll instead of wrap on the last row).
module termgrid
  import termgrid_pkg::*;
#(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_byte,
  input  logic       i_byte_v,
  input  logic       i_rdy,
  output logic [7:0] o_byte,
  output logic       o_byte_v,
  output logic       o_busy,
  output logic       o_drop
);

  localparam int unsigned AW = addr_width(ROWS, COLS);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned RW = $clog2(ROWS);

  localparam logic [AW-1:0] LAST_CELL = AW'(ROWS * COLS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [RW-1:0] cur_row, cur_row_nx;
  logic [CW-1:0] cur_col, cur_col_nx;
  logic [RW-1:0] top, top_nx;
  logic [RW-1:0] rd_row, rd_row_nx;
  logic [CW-1:0] rd_col, rd_col_nx;
  logic [1:0]    hcnt, hcnt_nx;
  logic          fin, fin_nx;
  logic [7:0]    ch, ch_nx;
`ifdef TERMGRID_SCROLL_EN
  logic [RW-1:0] clr_row, clr_row_nx;
`endif

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [AW-1:0] wr_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  logic          can_ld;
  logic          ld;
  logic [7:0]    ld_byte;
  logic          adv;

  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] t, input logic [RW-1:0] r);
    logic [RW:0] s;
    s = {1'b0, t} + {1'b0, r};
    if (s >= (RW+1)'(ROWS)) s = s - (RW+1)'(ROWS);
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  termgrid_ram #(
    .DEPTH(ROWS * COLS),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign o_busy = (state != S_IDLE);

  // FSM and screen-state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_INIT;
      cnt     <= '0;
      cur_row <= '0;
      cur_col <= '0;
      top     <= '0;
      rd_row  <= '0;
      rd_col  <= '0;
      hcnt    <= '0;
      fin     <= 1'b0;
      ch      <= '0;
`ifdef TERMGRID_SCROLL_EN
      clr_row <= '0;
`endif
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      cur_row <= cur_row_nx;
      cur_col <= cur_col_nx;
      top     <= top_nx;
      rd_row  <= rd_row_nx;
      rd_col  <= rd_col_nx;
      hcnt    <= hcnt_nx;
      fin     <= fin_nx;
      ch      <= ch_nx;
`ifdef TERMGRID_SCROLL_EN
      clr_row <= clr_row_nx;
`endif
    end
  end

  // Output byte register with valid/ready handshake and drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_byte   <= '0;
      o_byte_v <= 1'b0;
      o_drop   <= 1'b0;
    end else begin
      if (ld) begin
        o_byte   <= ld_byte;
        o_byte_v <= 1'b1;
      end else if (i_rdy) begin
        o_byte_v <= 1'b0;
      end
      o_drop <= i_byte_v && o_busy;
    end
  end

  // Next-state, grid update and redraw sequencing.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    cur_row_nx = cur_row;
    cur_col_nx = cur_col;
    top_nx     = top;
    rd_row_nx  = rd_row;
    rd_col_nx  = rd_col;
    hcnt_nx    = hcnt;
    fin_nx     = fin;
    ch_nx      = ch;
`ifdef TERMGRID_SCROLL_EN
    clr_row_nx = clr_row;
`endif
    ram_we     = 1'b0;
    ram_wdata  = CH_SPACE;
    wr_addr    = '0;
    ld         = 1'b0;
    ld_byte    = '0;
    adv        = 1'b0;
    can_ld     = !o_byte_v || i_rdy;

    case (state)
      S_INIT: begin
        ram_we  = 1'b1;
        wr_addr = cnt;
        if (cnt == LAST_CELL) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt + AW'(1);
        end
      end

      S_IDLE: begin
        if (i_byte_v && (is_printable(i_byte) || i_byte == CH_CR ||
                         i_byte == CH_LF || i_byte == CH_BS)) begin
          ch_nx    = i_byte;
          state_nx = S_UPDATE;
        end
      end

      S_UPDATE: begin
        state_nx  = S_HDR;
        hcnt_nx   = '0;
        rd_row_nx = '0;
        rd_col_nx = '0;
        fin_nx    = 1'b0;
        if (is_printable(ch)) begin
          ram_we    = 1'b1;
          ram_wdata = ch;
          wr_addr   = cell_addr(phys_row(top, cur_row), cur_col);
          if (cur_col == COL_LAST) begin
            cur_col_nx = '0;
            adv        = 1'b1;
          end else begin
            cur_col_nx = cur_col + CW'(1);
          end
        end else if (ch == CH_CR) begin
          cur_col_nx = '0;
        end else if (ch == CH_LF) begin
          adv = 1'b1;
        end else if (cur_col != '0) begin
          cur_col_nx = cur_col - CW'(1);
        end
        if (adv) begin
          if (cur_row != ROW_LAST) begin
            cur_row_nx = cur_row + RW'(1);
          end else begin
`ifdef TERMGRID_SCROLL_EN
            // Old top physical row becomes the new bottom row and is blanked.
            top_nx     = (top == ROW_LAST) ? '0 : top + RW'(1);
            clr_row_nx = top;
            cnt_nx     = '0;
            state_nx   = S_CLEAR;
`else
            cur_row_nx = '0;
`endif
          end
        end
      end

`ifdef TERMGRID_SCROLL_EN
      S_CLEAR: begin
        ram_we  = 1'b1;
        wr_addr = cell_addr(clr_row, cnt[CW-1:0]);
        if (cnt == AW'(COLS - 1)) begin
          cnt_nx   = '0;
          state_nx = S_HDR;
        end else begin
          cnt_nx = cnt + AW'(1);
        end
      end
`endif

      S_HDR: begin
        if (can_ld) begin
          ld      = 1'b1;
          ld_byte = (hcnt == 2'd0) ? CH_ESC : (hcnt == 2'd1) ? CH_LBRACK : CH_H;
          if (hcnt == 2'd2) state_nx = S_ROW;
          else              hcnt_nx  = hcnt + 2'd1;
        end
      end

      S_ROW: begin
        if (fin) begin
          // Last cell is held in the output register; leave once it is taken.
          if (i_rdy) state_nx = S_IDLE;
        end else if (can_ld) begin
          ld      = 1'b1;
          ld_byte = ram_rdata;
          if (rd_col == COL_LAST) begin
            rd_col_nx = '0;
            if (rd_row == ROW_LAST) begin
              fin_nx = 1'b1;
            end else begin
              rd_row_nx = rd_row + RW'(1);
              state_nx  = S_CR;
            end
          end else begin
            rd_col_nx = rd_col + CW'(1);
          end
        end
      end

      S_CR: begin
        if (can_ld) begin
          ld       = 1'b1;
          ld_byte  = CH_CR;
          state_nx = S_LF;
        end
      end

      S_LF: begin
        if (can_ld) begin
          ld       = 1'b1;
          ld_byte  = CH_LF;
          state_nx = S_ROW;
        end
      end

      default: state_nx = S_INIT;
    endcase

    // Reads address the cell the read pointer will hold next cycle, so
    // ram_rdata always matches the current read pointer, even across stalls.
    ram_addr = ram_we ? wr_addr : cell_addr(phys_row(top_nx, rd_row_nx), rd_col_nx);
  end

endmodule

// File: tb/tb_termgrid.sv
// Self-checking bench for termgrid: random bytes against a screen model.
module tb_termgrid;

  localparam int unsigned COLS  = 4;
  localparam int unsigned ROWS  = 2;
  localparam int unsigned NCELL = COLS * ROWS;
  localparam int unsigned LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_byte;
  logic       i_byte_v;
  logic       i_rdy;
  logic [7:0] o_byte;
  logic       o_byte_v;
  logic       o_busy;
  logic       o_drop;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned last_xfer_cyc = 0;
  int rdy_mode = 0;

  logic [7:0] got_q[$];
  logic [7:0] scr [ROWS][COLS];
  int unsigned mrow, mcol;

  termgrid #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_byte  (i_byte),
    .i_byte_v(i_byte_v),
    .i_rdy   (i_rdy),
    .o_byte  (o_byte),
    .o_byte_v(o_byte_v),
    .o_busy  (o_busy),
    .o_drop  (o_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Ready pattern: 0 always high, 1 alternating, 2 random.
  initial begin
    i_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       i_rdy = 1'b1;
        1:       i_rdy = ~i_rdy;
        default: i_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Transfer collector and stall-stability monitor, sampled on the falling edge.
  logic       stall_p = 1'b0;
  logic [7:0] stall_b = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        check("stall_valid", 32'(o_byte_v), 32'd1);
        check("stall_byte", 32'(o_byte), 32'(stall_b));
      end
      if (o_byte_v && i_rdy) begin
        got_q.push_back(o_byte);
        last_xfer_cyc = cyc;
      end
      stall_p = o_byte_v && !i_rdy;
      stall_b = o_byte;
    end
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int unsigned r = 0; r < ROWS; r++)
      for (int unsigned c = 0; c < COLS; c++)
        scr[r][c] = 8'h20;
    mrow = 0;
    mcol = 0;
  endtask

  task automatic model_newline(output bit scrolled);
    scrolled = 1'b0;
    if (mrow < ROWS - 1) begin
      mrow++;
    end else begin
`ifdef TERMGRID_SCROLL_EN
      for (int unsigned r = 0; r < ROWS - 1; r++) scr[r] = scr[r + 1];
      for (int unsigned c = 0; c < COLS; c++) scr[ROWS - 1][c] = 8'h20;
      scrolled = 1'b1;
`else
      mrow = 0;
`endif
    end
  endtask

  task automatic model_apply(input logic [7:0] b, output bit active, output bit scrolled);
    scrolled = 1'b0;
    active = 1'b1;
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[mrow][mcol] = b;
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        model_newline(scrolled);
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      model_newline(scrolled);
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else begin
      active = 1'b0;
    end
  endtask

  task automatic build_expected(output logic [7:0] q[$]);
    q.delete();
    q.push_back(8'h1B);
    q.push_back(8'h5B);
    q.push_back(8'h48);
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) q.push_back(scr[r][c]);
      if (r != ROWS - 1) begin
        q.push_back(8'h0D);
        q.push_back(8'h0A);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    int unsigned n = 0;
    while (o_busy !== 1'b0 && n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (o_busy !== 1'b0) check("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  // Starting right after the last reset edge, o_busy must hold for NCELL samples.
  task automatic init_count(input string tag);
    int unsigned n = 0;
    while (o_busy === 1'b1 && n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, NCELL);
  endtask

  task automatic send(input logic [7:0] b, input bit do_drop);
    bit act, scrl;
    int unsigned k;
    logic [7:0] exp_q[$];
    wait_idle();
    got_q.delete();
    i_byte   = b;
    i_byte_v = 1'b1;
    @(posedge clk);
    #1;
    i_byte_v = 1'b0;
    model_apply(b, act, scrl);
    if (!act) begin
      check("ign_busy", 32'(o_busy), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("ign_quiet", got_q.size(), 32'd0);
      return;
    end
    check("acc_busy", 32'(o_busy), 32'd1);
    k = 0;
    while (o_byte_v !== 1'b1 && k < LIMIT) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("esc_latency", k, scrl ? 2 + COLS : 2);
    check("esc_byte", 32'(o_byte), 32'h1B);
    if (do_drop) begin
      i_byte   = 8'h5A;
      i_byte_v = 1'b1;
      @(posedge clk);
      #1;
      i_byte_v = 1'b0;
      check("drop_pulse", 32'(o_drop), 32'd1);
      @(posedge clk);
      #1;
      check("drop_end", 32'(o_drop), 32'd0);
    end
    wait_idle();
    check("busy_fall", cyc, last_xfer_cyc + 1);
    build_expected(exp_q);
    check("redraw_len", got_q.size(), exp_q.size());
    for (int unsigned i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("redraw_byte", 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic send_str(input string s);
    for (int unsigned i = 0; i < s.len(); i++) send(s[i], 1'b0);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 9))
      6:       return 8'h0D;
      7:       return 8'h0A;
      8:       return 8'h08;
      9:       return 8'($urandom_range(0, 255));
      default: return 8'($urandom_range(32, 126));
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst      = 1'b1;
    i_byte   = '0;
    i_byte_v = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte", 32'(o_byte), 32'd0);
    check("rst_valid", 32'(o_byte_v), 32'd0);
    check("rst_drop", 32'(o_drop), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd1);
    rst = 1'b0;
    init_count("init_len");

    rdy_mode = 0;
    send_str("A");
    send_str("BCDE");

    rdy_mode = 1;
    send(8'h0D, 1'b0);
    send(8'h31, 1'b0);

    rdy_mode = 2;
    send(8'h32, 1'b1);
    send(8'h00, 1'b0);
    send(8'h7F, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h08, 1'b0);

    // Reset in the middle of a redraw.
    wait_idle();
    i_byte   = 8'h51;
    i_byte_v = 1'b1;
    @(posedge clk);
    #1;
    i_byte_v = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_valid", 32'(o_byte_v), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd1);
    init_count("midrst_init_len");
    model_reset();
    rdy_mode = 0;
    send_str("x");

    send_str("AB\n\nC");
    send_str("\r\n\n\n");

    for (int unsigned i = 0; i < 60; i++) begin
      rdy_mode = int'($urandom_range(0, 2));
      send(rand_byte(), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
